xif_coproc_alu: RTL and testbench
=================================

Name: xif_coproc_alu

Overview:
- Minimal CORE-V-XIF coprocessor that sits directly downstream of the cv32e40px core's XIF issue, commit and result ports.
- Accepts custom-0 R-type instructions, buffers them in-order until commit or kill, computes a 32-bit result and returns it on the result interface.
- Serves as the default X-heep reference coprocessor and as a bring-up target for the XIF path.

Parameters:
- DEPTH, 4, number of in-flight instruction slots (power of 2, >=2).
- ID_WIDTH, 4, width of XIF instruction id.
- OPCODE, 7'h0B, major opcode accepted (custom-0).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- issue_valid_i  in  1  issue request valid.
- issue_ready_o  out  1  issue request ready.
- issue_instr_i  in  32  offloaded instruction word.
- issue_id_i  in  ID_WIDTH  instruction id.
- issue_rs_i  in  2x32  source operands rs1 (index 0) and rs2 (index 1).
- issue_rs_valid_i  in  2  operand valid flags.
- issue_accept_o  out  1  response: instruction accepted.
- issue_writeback_o  out  1  response: will write rd.
- commit_valid_i  in  1  commit transaction valid.
- commit_id_i  in  ID_WIDTH  committed or killed id.
- commit_kill_i  in  1  1 = kill, 0 = commit.
- result_valid_o  out  1  result valid.
- result_ready_i  in  1  core ready for result.
- result_id_o  out  ID_WIDTH  id of result.
- result_data_o  out  32  result value.
- result_rd_o  out  5  destination register.
- result_we_o  out  1  register write enable.
- busy_o  out  1  any slot occupied or result pending.

Behaviour:
- Reset:
  - rst_i sampled on the rising edge of clk_i; while it is high, every output is 0, including issue_ready_o.
  - Reset mid-operation discards all slots and any pending result; no result is emitted afterwards.
- Decode:
  - Match condition: instr[6:0]==OPCODE, instr[31:25]==7'b0, and funct3 in {000 ADD, 001 XOR, 010 MIN (signed), 011 MAXU (unsigned)}.
  - issue_accept_o = match; issue_writeback_o = match && rd!=0. Both are combinational and only meaningful while issue_valid_i is high.
- Issue handshake, combinational:
  - Non-matching instruction: issue_ready_o = 1, so it is rejected immediately with no slot allocated.
  - Matching instruction: issue_ready_o = (count<DEPTH) && issue_rs_valid_i==2'b11.
  - count is the registered occupancy; a same-cycle retire does not free space (no bypass).
- Slot contents: valid, committed, killed, id, rd, funct3, rs1, rs2. Stored in a circular FIFO with head and tail pointers that wrap modulo DEPTH.
- Commit:
  - On commit_valid_i, every valid, uncommitted slot whose id equals commit_id_i sets committed (kill=0) or killed (kill=1).
  - If a commit arrives in the same cycle as an issue handshake with the same id, it applies to the newly written slot.
  - Commits for unknown ids are ignored.
- Retire (one per cycle, head only):
  - Head killed: pop the slot and produce no result.
  - Head committed and (!result_valid_o or result_ready_i): pop, compute via sub-module, and load the output register.
    - result_valid_o rises the cycle after the retire edge.
    - Minimum latency from the commit edge to result_valid_o is 1 cycle when the instruction is at the head.
- Result:
  - Output register contents are held stable while result_valid_o && !result_ready_i.
  - result_we_o = (rd!=0). Instructions with rd==0 still produce a result with result_we_o=0.
  - The register is cleared on handshake unless it is reloaded in the same cycle, which gives back-to-back throughput of one result per cycle.
- Arithmetic:
  - ADD: modulo 2^32.
  - XOR: bitwise.
  - MIN: signed two's-complement compare.
  - MAXU: unsigned compare.
- Full/empty:
  - count==DEPTH blocks matching issues only.
  - Empty FIFO with no pending result gives busy_o=0.
  - Results are returned strictly in issue order.

Decomposition:
- Package xif_coproc_pkg:
  - OPCODE default value.
  - funct3 enum: F3_ADD, F3_XOR, F3_MIN, F3_MAXU.
  - slot_t struct.
  - Decode function returning accept and writeback.
- Sub-module xif_coproc_alu_op: combinational, inputs funct3, a, b; output 32-bit result.

Test Plan:
- Reset held for 3 cycles, then released -> all outputs 0 during reset; issue_ready_o=1 and busy_o=0 in the first cycle after release.
- Issue ADD id=1 (rd=5, rs=0xFFFFFFFF, 0x2), then commit id=1 with kill=0 and result_ready_i=1 -> one cycle later result_valid_o=1, data=0x00000001, rd=5, we=1.
- Issue MIN id=2 (rs=0x80000000, 0x1) and MAXU id=3 (same operands), commit id=3 before id=2 -> results are returned in order: id=2 data=0x80000000, then id=3 data=0x80000000.
- Issue 4 ADDs (ids 0..3) with no commit -> a 5th matching issue sees issue_ready_o=0; a non-matching instruction (opcode 0x33) is still handshaked with accept=0.
- Issue ids 4, 5, 6; kill id=5, commit ids 4 and 6; hold result_ready_i=0 for 3 cycles -> id 4 result is held stable, id 5 produces no result, id 6 follows after ready rises.
- Issue XOR with rd=0 and commit it -> issue_writeback_o=0; result is emitted with we=0. Assert rst_i while it is pending -> result_valid_o=0 the next cycle and no later result.

Source files
------------

// File: rtl/xif_coproc_pkg.sv
// Shared types, defaults and instruction decode for the XIF coprocessor ALU.
package xif_coproc_pkg;

    localparam logic [6:0]  OPCODE_DEFAULT = 7'h0B;
    localparam int unsigned XLEN           = 32;
    localparam int unsigned MAX_ID_WIDTH   = 8;

    typedef enum logic [2:0] {
        F3_ADD  = 3'b000,
        F3_XOR  = 3'b001,
        F3_MIN  = 3'b010,
        F3_MAXU = 3'b011
    } funct3_e;

    typedef struct packed {
        logic                    valid;
        logic                    committed;
        logic                    killed;
        logic [MAX_ID_WIDTH-1:0] id;
        logic [4:0]              rd;
        funct3_e                 funct3;
        logic [XLEN-1:0]         rs1;
        logic [XLEN-1:0]         rs2;
    } slot_t;

    typedef struct packed {
        logic accept;
        logic writeback;
    } decode_t;

    // Supported funct3 values are 000..011, so bit 14 must be clear.
    function automatic decode_t decode(input logic [31:0] instr, input logic [6:0] opcode);
        decode_t d;
        d.accept    = (instr[6:0] == opcode) && (instr[31:25] == 7'b0) && !instr[14];
        d.writeback = d.accept && (instr[11:7] != 5'd0);
        return d;
    endfunction

endpackage

// File: rtl/xif_coproc_alu_op.sv
// Combinational datapath for the four supported custom-0 operations.
module xif_coproc_alu_op
    import xif_coproc_pkg::*;
(
    input  funct3_e          funct3,
    input  logic [XLEN-1:0]  a,
    input  logic [XLEN-1:0]  b,
    output logic [XLEN-1:0]  result
);

    always_comb begin
        result = '0;
        case (funct3)
            F3_ADD:  result = a + b;
            F3_XOR:  result = a ^ b;
            F3_MIN:  result = ($signed(a) < $signed(b)) ? a : b;
            F3_MAXU: result = (a > b) ? a : b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/xif_coproc_alu.sv
// CORE-V-XIF coprocessor: in-order slot FIFO held until commit/kill, one retire per cycle,
// registered result port.
module xif_coproc_alu
    import xif_coproc_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ID_WIDTH = 4,
    parameter logic [6:0]  OPCODE   = OPCODE_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                issue_valid_i,
    output logic                issue_ready_o,
    input  logic [31:0]         issue_instr_i,
    input  logic [ID_WIDTH-1:0] issue_id_i,
    input  logic [1:0][31:0]    issue_rs_i,
    input  logic [1:0]          issue_rs_valid_i,
    output logic                issue_accept_o,
    output logic                issue_writeback_o,
    input  logic                commit_valid_i,
    input  logic [ID_WIDTH-1:0] commit_id_i,
    input  logic                commit_kill_i,
    output logic                result_valid_o,
    input  logic                result_ready_i,
    output logic [ID_WIDTH-1:0] result_id_o,
    output logic [31:0]         result_data_o,
    output logic [4:0]          result_rd_o,
    output logic                result_we_o,
    output logic                busy_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    slot_t             slots [DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;

    decode_t           dec;
    slot_t             head_slot;
    logic [XLEN-1:0]   alu_result;
    logic              issue_fire;
    logic              can_load;
    logic              retire_kill;
    logic              retire_res;
    logic              pop;
    logic              new_commit_hit;

    assign dec               = decode(issue_instr_i, OPCODE);
    assign issue_accept_o    = !rst_i && dec.accept;
    assign issue_writeback_o = !rst_i && dec.writeback;

    // Non-matching instructions are always taken (and rejected); matching ones need space and operands.
    assign issue_ready_o = !rst_i &&
                           (!dec.accept || ((count < CNT_W'(DEPTH)) && (issue_rs_valid_i == 2'b11)));
    assign issue_fire    = issue_valid_i && issue_ready_o && dec.accept;

    assign head_slot   = slots[head];
    assign can_load    = !result_valid_o || result_ready_i;
    assign retire_kill = (count != '0) && head_slot.killed;
    assign retire_res  = (count != '0) && head_slot.committed && !head_slot.killed && can_load;
    assign pop         = retire_kill || retire_res;

    assign new_commit_hit = commit_valid_i && (commit_id_i == issue_id_i);

    assign busy_o = !rst_i && ((count != '0) || result_valid_o);

    xif_coproc_alu_op u_alu_op (
        .funct3 (head_slot.funct3),
        .a      (head_slot.rs1),
        .b      (head_slot.rs2),
        .result (alu_result)
    );

    // Slot FIFO, commit tracking and result register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            head           <= '0;
            tail           <= '0;
            count          <= '0;
            result_valid_o <= 1'b0;
            result_id_o    <= '0;
            result_data_o  <= '0;
            result_rd_o    <= '0;
            result_we_o    <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                slots[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (commit_valid_i && slots[i].valid && !slots[i].committed && !slots[i].killed &&
                    (slots[i].id == MAX_ID_WIDTH'(commit_id_i))) begin
                    if (commit_kill_i) slots[i].killed    <= 1'b1;
                    else               slots[i].committed <= 1'b1;
                end
            end

            if (pop) begin
                slots[head].valid <= 1'b0;
                head              <= head + PTR_W'(1);
            end

            // Written last so a same-cycle commit for the new id lands on the fresh slot.
            if (issue_fire) begin
                slots[tail].valid     <= 1'b1;
                slots[tail].committed <= new_commit_hit && !commit_kill_i;
                slots[tail].killed    <= new_commit_hit && commit_kill_i;
                slots[tail].id        <= MAX_ID_WIDTH'(issue_id_i);
                slots[tail].rd        <= issue_instr_i[11:7];
                slots[tail].funct3    <= funct3_e'(issue_instr_i[14:12]);
                slots[tail].rs1       <= issue_rs_i[0];
                slots[tail].rs2       <= issue_rs_i[1];
                tail                  <= tail + PTR_W'(1);
            end

            count <= count + CNT_W'(issue_fire) - CNT_W'(pop);

            if (retire_res) begin
                result_valid_o <= 1'b1;
                result_id_o    <= ID_WIDTH'(head_slot.id);
                result_data_o  <= alu_result;
                result_rd_o    <= head_slot.rd;
                result_we_o    <= (head_slot.rd != 5'd0);
            end else if (result_valid_o && result_ready_i) begin
                result_valid_o <= 1'b0;
                result_id_o    <= '0;
                result_data_o  <= '0;
                result_rd_o    <= '0;
                result_we_o    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_xif_coproc_alu.sv
// Self-checking bench for xif_coproc_alu: decode/ALU table, directed XIF sequences and a
// randomized run scored against an in-order queue model.
module tb_xif_coproc_alu;

    logic             clk = 1'b0;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready_o;
    logic [31:0]      issue_instr;
    logic [3:0]       issue_id;
    logic [1:0][31:0] issue_rs;
    logic [1:0]       issue_rs_valid;
    logic             issue_accept_o;
    logic             issue_writeback_o;
    logic             commit_valid;
    logic [3:0]       commit_id;
    logic             commit_kill;
    logic             result_valid_o;
    logic             result_ready;
    logic [3:0]       result_id_o;
    logic [31:0]      result_data_o;
    logic [4:0]       result_rd_o;
    logic             result_we_o;
    logic             busy_o;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic        acc;
        logic        wb;
        logic [31:0] data;
    } vec_t;

    typedef struct {
        logic [3:0]  id;
        logic [4:0]  rd;
        logic [31:0] data;
        int          st;    // 0 waiting, 1 committed, 2 killed
    } ent_t;

    ent_t       pend[$];
    logic [3:0] next_id;

    xif_coproc_alu dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .issue_valid_i     (issue_valid),
        .issue_ready_o     (issue_ready_o),
        .issue_instr_i     (issue_instr),
        .issue_id_i        (issue_id),
        .issue_rs_i        (issue_rs),
        .issue_rs_valid_i  (issue_rs_valid),
        .issue_accept_o    (issue_accept_o),
        .issue_writeback_o (issue_writeback_o),
        .commit_valid_i    (commit_valid),
        .commit_id_i       (commit_id),
        .commit_kill_i     (commit_kill),
        .result_valid_o    (result_valid_o),
        .result_ready_i    (result_ready),
        .result_id_o       (result_id_o),
        .result_data_o     (result_data_o),
        .result_rd_o       (result_rd_o),
        .result_we_o       (result_we_o),
        .busy_o            (busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3,
                                       input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd2, 5'd1, f3, rd, op};
    endfunction

    // Reference arithmetic straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] b);
        int signed sa;
        int signed sb;
        sa = a;
        sb = b;
        case (f3)
            3'd0:    return a + b;
            3'd1:    return a ^ b;
            3'd2:    return (sa < sb) ? a : b;
            default: return (a > b) ? a : b;
        endcase
    endfunction

    task automatic idle();
        issue_valid    = 1'b0;
        issue_instr    = '0;
        issue_id       = '0;
        issue_rs       = '0;
        issue_rs_valid = 2'b00;
        commit_valid   = 1'b0;
        commit_id      = '0;
        commit_kill    = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic do_issue(input logic [3:0] id, input logic [31:0] instr, input logic [31:0] a,
                            input logic [31:0] b, output logic acc, output logic wb);
        int k;
        issue_valid    = 1'b1;
        issue_id       = id;
        issue_instr    = instr;
        issue_rs[0]    = a;
        issue_rs[1]    = b;
        issue_rs_valid = 2'b11;
        k = 0;
        @(negedge clk);
        while (!issue_ready_o && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("issue_ready_wait", 64'(issue_ready_o), 64'(1));
        acc = issue_accept_o;
        wb  = issue_writeback_o;
        step();
        issue_valid    = 1'b0;
        issue_rs_valid = 2'b00;
        issue_instr    = '0;
    endtask

    task automatic do_commit(input logic [3:0] id, input logic kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        step();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    // cyc counts rising edges after the call point until result_valid_o is seen; ends on a negedge.
    task automatic wait_result(input int budget, output int cyc);
        cyc = 0;
        @(negedge clk);
        while (!result_valid_o && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("result_wait", 64'(result_valid_o), 64'(1));
    endtask

    task automatic rnd_cycle(input bit allow_issue);
        logic [31:0] a, b;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [6:0]  op, f7;
        logic [3:0]  cid;
        bit          do_iss, do_com, com_new, exp_acc, ckill, clash;
        int          ci;
        int          cand[$];

        idle();
        do_iss  = allow_issue && ($urandom_range(0, 2) != 0);
        exp_acc = 1'b0;
        f3 = '0; rd = '0; a = '0; b = '0;
        if (do_iss) begin
            f3 = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            op = ($urandom_range(0, 11) == 0) ? 7'h33 : 7'h0B;
            f7 = ($urandom_range(0, 11) == 0) ? 7'h20 : 7'h00;
            rd = 5'($urandom);
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
            exp_acc        = (op == 7'h0B) && (f7 == 7'h00) && (f3 < 3'd4);
            issue_valid    = 1'b1;
            issue_id       = next_id;
            issue_instr    = {f7, 5'($urandom), 5'($urandom), f3, rd, op};
            issue_rs[0]    = a;
            issue_rs[1]    = b;
            issue_rs_valid = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
        end

        do_com  = ($urandom_range(0, 2) == 0);
        com_new = 1'b0;
        ci      = -1;
        cid     = '0;
        ckill   = ($urandom_range(0, 3) == 0);
        if (do_com) begin
            case ($urandom_range(0, 9))
                0: begin
                    if (do_iss) begin cid = next_id; com_new = 1'b1; end
                    else do_com = 1'b0;
                end
                1: begin
                    cid   = next_id ^ 4'h8;
                    clash = 1'b0;
                    foreach (pend[i]) if (pend[i].id == cid && pend[i].st == 0) clash = 1'b1;
                    if (clash) do_com = 1'b0;
                end
                default: begin
                    foreach (pend[i]) if (pend[i].st == 0) cand.push_back(i);
                    if (cand.size() == 0) do_com = 1'b0;
                    else begin
                        ci  = cand[$urandom_range(0, cand.size() - 1)];
                        cid = pend[ci].id;
                    end
                end
            endcase
        end
        if (do_com) begin
            commit_valid = 1'b1;
            commit_id    = cid;
            commit_kill  = ckill;
        end
        result_ready = ($urandom_range(0, 3) != 0);

        @(negedge clk);
        if (ci >= 0) pend[ci].st = ckill ? 2 : 1;
        if (do_iss) begin
            chk("rnd_accept", 64'(issue_accept_o), 64'(exp_acc));
            chk("rnd_writeback", 64'(issue_writeback_o), 64'(exp_acc && rd != 5'd0));
            if (!exp_acc) chk("rnd_nonmatch_ready", 64'(issue_ready_o), 64'(1));
            else if (issue_rs_valid != 2'b11) chk("rnd_rs_invalid_ready", 64'(issue_ready_o), 64'(0));
            else if (issue_ready_o) begin
                pend.push_back('{id: next_id, rd: rd, data: ref_alu(f3, a, b),
                                 st: com_new ? (ckill ? 2 : 1) : 0});
                next_id = next_id + 4'd1;
            end
        end
        if (result_valid_o && result_ready) begin
            while (pend.size() > 0 && pend[0].st == 2) void'(pend.pop_front());
            chk("rnd_result_expected", 64'(pend.size() > 0), 64'(1));
            if (pend.size() > 0) begin
                chk("rnd_result_committed", 64'(pend[0].st), 64'(1));
                chk("rnd_result_id", 64'(result_id_o), 64'(pend[0].id));
                chk("rnd_result_data", 64'(result_data_o), 64'(pend[0].data));
                chk("rnd_result_rd", 64'(result_rd_o), 64'(pend[0].rd));
                chk("rnd_result_we", 64'(result_we_o), 64'(pend[0].rd != 5'd0));
                void'(pend.pop_front());
            end
        end
        step();
    endtask

    initial begin
        vec_t       vecs[10];
        logic       acc, wb;
        int         cyc;
        bit         saw, live;
        logic [31:0] hold_data;

        idle();
        rst          = 1'b1;
        result_ready = 1'b0;
        next_id      = 4'd8;

        // Reset: every output low while rst is high.
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs_zero",
                64'({issue_ready_o, issue_accept_o, issue_writeback_o, result_valid_o, result_id_o,
                     result_data_o, result_rd_o, result_we_o, busy_o}), 64'(0));
        end
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_ready", 64'(issue_ready_o), 64'(1));
        chk("post_reset_busy", 64'(busy_o), 64'(0));
        step();

        // Decode and arithmetic table.
        vecs[0] = '{mk(7'h00, 3'd0, 5'd3, 7'h0B), 32'h7FFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'h8000_0000};
        vecs[1] = '{mk(7'h00, 3'd0, 5'd0, 7'h0B), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFE};
        vecs[2] = '{mk(7'h00, 3'd1, 5'd4, 7'h0B), 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b1, 1'b1, 32'hFF00_FF00};
        vecs[3] = '{mk(7'h00, 3'd2, 5'd4, 7'h0B), 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[4] = '{mk(7'h00, 3'd2, 5'd9, 7'h0B), 32'h0000_0005, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0003};
        vecs[5] = '{mk(7'h00, 3'd3, 5'd9, 7'h0B), 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b1, 32'hFFFF_FFFF};
        vecs[6] = '{mk(7'h00, 3'd3, 5'd1, 7'h0B), 32'h0000_0010, 32'h0000_0020, 1'b1, 1'b1, 32'h0000_0020};
        vecs[7] = '{mk(7'h00, 3'd4, 5'd1, 7'h0B), 32'h1, 32'h2, 1'b0, 1'b0, 32'h0};
        vecs[8] = '{mk(7'h20, 3'd0, 5'd1, 7'h0B), 32'h1, 32'h2, 1'b0, 1'b0, 32'h0};
        vecs[9] = '{mk(7'h00, 3'd0, 5'd1, 7'h33), 32'h1, 32'h2, 1'b0, 1'b0, 32'h0};
        result_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            do_issue(4'(i), vecs[i].instr, vecs[i].a, vecs[i].b, acc, wb);
            chk($sformatf("vec%0d_accept", i), 64'(acc), 64'(vecs[i].acc));
            chk($sformatf("vec%0d_writeback", i), 64'(wb), 64'(vecs[i].wb));
            if (vecs[i].acc) begin
                do_commit(4'(i), 1'b0);
                wait_result(10, cyc);
                chk($sformatf("vec%0d_data", i), 64'(result_data_o), 64'(vecs[i].data));
                chk($sformatf("vec%0d_we", i), 64'(result_we_o), 64'(vecs[i].wb));
                step();
            end
        end

        // ADD with wraparound, result one cycle after the commit edge.
        do_issue(4'd1, mk(7'h00, 3'd0, 5'd5, 7'h0B), 32'hFFFF_FFFF, 32'h2, acc, wb);
        chk("add_accept", 64'({acc, wb}), 64'(2'b11));
        do_commit(4'd1, 1'b0);
        wait_result(10, cyc);
        chk("add_latency", 64'(cyc), 64'(1));
        chk("add_result",
            64'({result_id_o, result_data_o, result_rd_o, result_we_o}),
            64'({4'd1, 32'h0000_0001, 5'd5, 1'b1}));
        step();
        @(negedge clk);
        chk("add_drained", 64'({result_valid_o, busy_o}), 64'(0));
        step();

        // Out-of-order commits still return results in issue order.
        do_issue(4'd2, mk(7'h00, 3'd2, 5'd6, 7'h0B), 32'h8000_0000, 32'h1, acc, wb);
        do_issue(4'd3, mk(7'h00, 3'd3, 5'd7, 7'h0B), 32'h8000_0000, 32'h1, acc, wb);
        do_commit(4'd3, 1'b0);
        do_commit(4'd2, 1'b0);
        wait_result(10, cyc);
        chk("order_first", 64'({result_id_o, result_data_o}), 64'({4'd2, 32'h8000_0000}));
        step();
        wait_result(10, cyc);
        chk("order_second", 64'({result_id_o, result_data_o}), 64'({4'd3, 32'h8000_0000}));
        step();

        // Full FIFO blocks matching issues only.
        for (int i = 0; i < 4; i++) begin
            do_issue(4'(i), mk(7'h00, 3'd0, 5'd1, 7'h0B), 32'(i), 32'h1, acc, wb);
        end
        issue_valid    = 1'b1;
        issue_id       = 4'd4;
        issue_instr    = mk(7'h00, 3'd0, 5'd1, 7'h0B);
        issue_rs_valid = 2'b11;
        @(negedge clk);
        chk("full_blocks_match", 64'(issue_ready_o), 64'(0));
        chk("full_busy", 64'(busy_o), 64'(1));
        #1;
        issue_instr = mk(7'h00, 3'd0, 5'd1, 7'h33);
        #1;
        chk("full_nonmatch_handshake", 64'({issue_ready_o, issue_accept_o}), 64'(2'b10));
        step();
        idle();
        for (int i = 0; i < 4; i++) do_commit(4'(i), 1'b1);
        saw = 1'b0;
        cyc = 0;
        @(negedge clk);
        while (busy_o && cyc < 10) begin
            if (result_valid_o) saw = 1'b1;
            @(negedge clk);
            cyc++;
        end
        chk("killed_no_result", 64'(saw | result_valid_o), 64'(0));
        chk("killed_drained_busy", 64'(busy_o), 64'(0));
        step();

        // Back-pressure: held result, killed middle entry, follow-on after ready.
        result_ready = 1'b0;
        do_issue(4'd4, mk(7'h00, 3'd0, 5'd8, 7'h0B), 32'd10, 32'd20, acc, wb);
        do_issue(4'd5, mk(7'h00, 3'd1, 5'd8, 7'h0B), 32'hFF, 32'h0F, acc, wb);
        do_issue(4'd6, mk(7'h00, 3'd3, 5'd9, 7'h0B), 32'd5, 32'd9, acc, wb);
        do_commit(4'd5, 1'b1);
        do_commit(4'd4, 1'b0);
        do_commit(4'd6, 1'b0);
        wait_result(10, cyc);
        chk("bp_first", 64'({result_id_o, result_data_o}), 64'({4'd4, 32'd30}));
        hold_data = 32'd30;
        repeat (3) begin
            step();
            @(negedge clk);
            chk("bp_hold", 64'({result_valid_o, result_id_o, result_data_o, result_rd_o}),
                64'({1'b1, 4'd4, hold_data, 5'd8}));
        end
        result_ready = 1'b1;
        step();
        @(negedge clk);
        chk("bp_next_after_ready",
            64'({result_valid_o, result_id_o, result_data_o, result_rd_o, result_we_o}),
            64'({1'b1, 4'd6, 32'd9, 5'd9, 1'b1}));
        step();
        @(negedge clk);
        chk("bp_drained", 64'({result_valid_o, busy_o}), 64'(0));
        step();

        // Randomized traffic against the queue model.
        for (int n = 0; n < 600; n++) rnd_cycle(1'b1);
        for (int n = 0; n < 400; n++) begin
            live = 1'b0;
            foreach (pend[i]) if (pend[i].st != 2) live = 1'b1;
            if (!live && !busy_o) break;
            rnd_cycle(1'b0);
        end
        idle();
        live = 1'b0;
        foreach (pend[i]) if (pend[i].st != 2) live = 1'b1;
        chk("rnd_all_returned", 64'(live), 64'(0));
        result_ready = 1'b1;
        repeat (3) step();
        @(negedge clk);
        chk("rnd_idle_busy", 64'(busy_o), 64'(0));
        step();

        // rd==0 result, then reset while it is pending.
        result_ready = 1'b0;
        do_issue(4'd7, mk(7'h00, 3'd1, 5'd0, 7'h0B), 32'hA5A5_A5A5, 32'hFFFF_0000, acc, wb);
        chk("x0_decode", 64'({acc, wb}), 64'(2'b10));
        do_commit(4'd7, 1'b0);
        wait_result(10, cyc);
        chk("x0_result", 64'({result_id_o, result_data_o, result_rd_o, result_we_o}),
            64'({4'd7, 32'h5A5A_A5A5, 5'd0, 1'b0}));
        rst = 1'b1;
        step();
        @(negedge clk);
        chk("reset_kills_result", 64'({result_valid_o, busy_o}), 64'(0));
        step();
        rst          = 1'b0;
        result_ready = 1'b1;
        saw = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (result_valid_o || busy_o) saw = 1'b1;
        end
        chk("reset_no_late_result", 64'(saw), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
